mem_tracker: RTL and testbench
==============================

MEM_TRACKER -- requirements
Module: mem_tracker

Interface
REQ-001 SHALL have parameter INSTR_ADDR_WIDTH, default 16, instruction address width.
REQ-002 SHALL have parameter INSTR_DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter DATA_ADDR_WIDTH, default 32, data memory address width.
REQ-004 SHALL have parameter PENDING_DEPTH, default 4, pending load/store FIFO depth (power of 2, >=2).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port counter, input, 32 (integer), free-running cycle timestamp.
REQ-009 SHALL have port if_data_ready, input, 1, single-cycle strobe: one load/store record from the fetch tracker.
REQ-010 SHALL have port if_instruction, input, INSTR_DATA_WIDTH, instruction word of the load/store.
REQ-011 SHALL have port if_instr_addr, input, INSTR_ADDR_WIDTH, fetch address of the load/store.
REQ-012 SHALL have port dec_stage_end, input, 32, decode-end timestamp of the load/store.
REQ-013 SHALL have ports data_req, data_gnt, data_rvalid, data_we, input, 1 each, data memory handshake and write enable.
REQ-014 SHALL have port data_addr, input, DATA_ADDR_WIDTH, data memory address.
REQ-015 SHALL have port trace_valid, output, 1, one-cycle strobe: trace record valid.
REQ-016 SHALL have ports trace_instruction, trace_instr_addr, trace_dec_end, output, matching input widths, paired fetch-side fields.
REQ-017 SHALL have ports trace_mem_addr (DATA_ADDR_WIDTH) and trace_we (1), output, memory-side fields.
REQ-018 SHALL have ports trace_req_time, trace_gnt_time, trace_rvalid_time, output, 32 each, memory handshake timestamps.
REQ-019 SHALL have ports trace_orphan and overflow, output, 1 each: record had no pending instruction; sticky FIFO overflow flag.

Function
REQ-020 SHALL push {if_instruction, if_instr_addr, dec_stage_end} into the pending FIFO on every cycle with if_data_ready=1.
REQ-021 SHALL, on a push while the FIFO holds PENDING_DEPTH entries, drop the new entry, keep the existing entries, and set overflow=1 until reset.
REQ-022 SHALL run memory FSM states IDLE, WAIT_GNT, WAIT_RVALID.
REQ-023 SHALL, in IDLE with data_req=1, capture req_time=counter and move to WAIT_GNT.
REQ-024 SHALL, in WAIT_GNT with data_gnt=1, capture data_addr, data_we, gnt_time=counter and move to WAIT_RVALID.
REQ-025 SHALL, when data_req and data_gnt are both 1 in IDLE, capture req_time and gnt_time as the same counter value and move directly to WAIT_RVALID.
REQ-026 SHALL, in WAIT_RVALID with data_rvalid=1, capture rvalid_time=counter, pop the FIFO head, and pair it with the captured memory fields.
REQ-027 SHALL, on data_rvalid with data_req=1 in the same cycle, start the next transaction (req_time=counter, state WAIT_GNT) with no idle cycle.
REQ-028 SHALL assert trace_valid for exactly one cycle, one cycle after the data_rvalid cycle, with all trace_* fields stable in that cycle.
REQ-029 SHALL, on a pop from an empty FIFO, output trace_instruction=0, trace_instr_addr=0, trace_dec_end=0, trace_orphan=1.
REQ-030 SHALL, on a simultaneous push and pop, pop the old head and push the new entry, leaving the count unchanged. When the FIFO is empty, the pushed entry is not bypassed and the record is orphan.
REQ-031 SHALL wrap FIFO read and write pointers modulo PENDING_DEPTH and SHALL hold trace_* fields between strobes.

Reset
REQ-032 SHALL, when rst_n=0 at a clock edge, empty the FIFO, set the FSM to IDLE, and zero trace_valid, every trace_* field, trace_orphan and overflow.
REQ-033 SHALL, on a reset mid-transaction, discard the in-flight transaction so no trace_valid is produced for it.

Verification
REQ-034 Single load: push instr 0x00412083 addr 0x0100 dec_end 10, then req@12, gnt@13, rvalid@15 addr 0x2000 we=0 -> trace_valid@16 with req/gnt/rvalid=12/13/15, addr 0x2000, orphan=0.
REQ-035 Back-to-back: two pushes, then a second req in the rvalid cycle of the first -> two records in push order, second req_time equals first rvalid_time.
REQ-036 Overflow: 5 pushes with depth 4 and no memory traffic -> overflow=1. The next 4 records return pushes 1-4, and the 5th push never appears.
REQ-037 Orphan: memory transaction with empty FIFO -> trace_valid with orphan=1, instruction=0.
REQ-038 Reset in WAIT_RVALID: rst_n=0 one cycle, then a stray rvalid -> no trace_valid and the FSM stays IDLE.
REQ-039 Same-cycle req+gnt at counter=20 -> req_time=gnt_time=20.

Source files
------------

// File: rtl/mem_tracker.sv
// Pairs load/store records from the fetch tracker with data-memory handshakes
// and emits one trace record per completed memory transaction.
module mem_tracker #(
  parameter int INSTR_ADDR_WIDTH = 16,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int PENDING_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 counter,
  input  logic                        if_data_ready,
  input  logic [INSTR_DATA_WIDTH-1:0] if_instruction,
  input  logic [INSTR_ADDR_WIDTH-1:0] if_instr_addr,
  input  logic [31:0]                 dec_stage_end,
  input  logic                        data_req,
  input  logic                        data_gnt,
  input  logic                        data_rvalid,
  input  logic                        data_we,
  input  logic [DATA_ADDR_WIDTH-1:0]  data_addr,
  output logic                        trace_valid,
  output logic [INSTR_DATA_WIDTH-1:0] trace_instruction,
  output logic [INSTR_ADDR_WIDTH-1:0] trace_instr_addr,
  output logic [31:0]                 trace_dec_end,
  output logic [DATA_ADDR_WIDTH-1:0]  trace_mem_addr,
  output logic                        trace_we,
  output logic [31:0]                 trace_req_time,
  output logic [31:0]                 trace_gnt_time,
  output logic [31:0]                 trace_rvalid_time,
  output logic                        trace_orphan,
  output logic                        overflow
);

  localparam int PW = $clog2(PENDING_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t                      r_state;
  logic [INSTR_DATA_WIDTH-1:0] r_fifo_instr [PENDING_DEPTH];
  logic [INSTR_ADDR_WIDTH-1:0] r_fifo_iaddr [PENDING_DEPTH];
  logic [31:0]                 r_fifo_dec   [PENDING_DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [PW:0]                 r_count;
  logic [31:0]                 r_req_time;
  logic [31:0]                 r_gnt_time;
  logic [DATA_ADDR_WIDTH-1:0]  r_mem_addr;
  logic                        r_mem_we;

  logic w_empty, w_full, w_pop, w_push_ok, w_pop_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PW+1)'(PENDING_DEPTH));
  assign w_pop     = (r_state == WAIT_RVALID) && data_rvalid;
  // A full FIFO drops the incoming entry even if a pop happens in the same cycle.
  assign w_push_ok = if_data_ready && !w_full;
  assign w_pop_ok  = w_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_instr[r_wr_ptr] <= if_instruction;
      r_fifo_iaddr[r_wr_ptr] <= if_instr_addr;
      r_fifo_dec[r_wr_ptr]   <= dec_stage_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (if_data_ready && w_full) overflow <= 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_req_time        <= '0;
      r_gnt_time        <= '0;
      r_mem_addr        <= '0;
      r_mem_we          <= 1'b0;
      trace_valid       <= 1'b0;
      trace_instruction <= '0;
      trace_instr_addr  <= '0;
      trace_dec_end     <= '0;
      trace_mem_addr    <= '0;
      trace_we          <= 1'b0;
      trace_req_time    <= '0;
      trace_gnt_time    <= '0;
      trace_rvalid_time <= '0;
      trace_orphan      <= 1'b0;
    end else begin
      trace_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (data_req) begin
            r_req_time <= counter;
            if (data_gnt) begin
              r_gnt_time <= counter;
              r_mem_addr <= data_addr;
              r_mem_we   <= data_we;
              r_state    <= WAIT_RVALID;
            end else begin
              r_state <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt) begin
            r_gnt_time <= counter;
            r_mem_addr <= data_addr;
            r_mem_we   <= data_we;
            r_state    <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid) begin
            trace_valid       <= 1'b1;
            trace_mem_addr    <= r_mem_addr;
            trace_we          <= r_mem_we;
            trace_req_time    <= r_req_time;
            trace_gnt_time    <= r_gnt_time;
            trace_rvalid_time <= counter;
            trace_orphan      <= w_empty;
            trace_instruction <= w_empty ? '0 : r_fifo_instr[r_rd_ptr];
            trace_instr_addr  <= w_empty ? '0 : r_fifo_iaddr[r_rd_ptr];
            trace_dec_end     <= w_empty ? '0 : r_fifo_dec[r_rd_ptr];
            // A request in the completion cycle chains straight into WAIT_GNT.
            if (data_req) begin
              r_req_time <= counter;
              r_state    <= WAIT_GNT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tracker.sv
// Scoreboard bench for mem_tracker: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_mem_tracker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] counter;
  logic        if_data_ready;
  logic [31:0] if_instruction;
  logic [15:0] if_instr_addr;
  logic [31:0] dec_stage_end;
  logic        data_req, data_gnt, data_rvalid, data_we;
  logic [31:0] data_addr;
  logic        trace_valid;
  logic [31:0] trace_instruction;
  logic [15:0] trace_instr_addr;
  logic [31:0] trace_dec_end;
  logic [31:0] trace_mem_addr;
  logic        trace_we;
  logic [31:0] trace_req_time, trace_gnt_time, trace_rvalid_time;
  logic        trace_orphan;
  logic        overflow;

  mem_tracker #(
    .INSTR_ADDR_WIDTH(16),
    .INSTR_DATA_WIDTH(32),
    .DATA_ADDR_WIDTH (32),
    .PENDING_DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .counter          (counter),
    .if_data_ready    (if_data_ready),
    .if_instruction   (if_instruction),
    .if_instr_addr    (if_instr_addr),
    .dec_stage_end    (dec_stage_end),
    .data_req         (data_req),
    .data_gnt         (data_gnt),
    .data_rvalid      (data_rvalid),
    .data_we          (data_we),
    .data_addr        (data_addr),
    .trace_valid      (trace_valid),
    .trace_instruction(trace_instruction),
    .trace_instr_addr (trace_instr_addr),
    .trace_dec_end    (trace_dec_end),
    .trace_mem_addr   (trace_mem_addr),
    .trace_we         (trace_we),
    .trace_req_time   (trace_req_time),
    .trace_gnt_time   (trace_gnt_time),
    .trace_rvalid_time(trace_rvalid_time),
    .trace_orphan     (trace_orphan),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] iaddr;
    logic [31:0] dec;
  } pend_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] iaddr;
    logic [31:0] dec;
    logic [31:0] maddr;
    logic        we;
    logic [31:0] req_t;
    logic [31:0] gnt_t;
    logic [31:0] rv_t;
    logic        orphan;
  } rec_t;

  int checks = 0;
  int failures = 0;

  pend_t pend_q[$];
  rec_t  exp_q[$];

  // Transaction-level model: a request is outstanding, then granted, then completes.
  bit          m_have_req, m_have_gnt;
  logic [31:0] m_req_t, m_gnt_t, m_addr;
  logic        m_we;
  bit          m_ovf_next, m_ovf_vis;
  bit          mon_en = 1'b0;

  task automatic model_eval();
    rec_t  r;
    pend_t p;
    bit    pop;
    int    sz;
    if (!rst_n) begin
      pend_q.delete();
      m_have_req = 0;
      m_have_gnt = 0;
      m_ovf_next = 0;
      return;
    end
    sz  = pend_q.size();
    pop = m_have_gnt && data_rvalid;
    if (pop) begin
      if (sz > 0) begin
        p = pend_q.pop_front();
        r.instr = p.instr; r.iaddr = p.iaddr; r.dec = p.dec; r.orphan = 1'b0;
      end else begin
        r.instr = '0; r.iaddr = '0; r.dec = '0; r.orphan = 1'b1;
      end
      r.maddr = m_addr; r.we = m_we;
      r.req_t = m_req_t; r.gnt_t = m_gnt_t; r.rv_t = counter;
      exp_q.push_back(r);
    end
    if (if_data_ready) begin
      if (sz >= DEPTH) m_ovf_next = 1;
      else pend_q.push_back({if_instruction, if_instr_addr, dec_stage_end});
    end
    if (pop) begin
      m_have_gnt = 0;
      m_have_req = data_req;
      if (data_req) m_req_t = counter;
    end else if (!m_have_req) begin
      if (data_req) begin
        m_have_req = 1;
        m_req_t = counter;
        if (data_gnt) begin
          m_have_gnt = 1; m_gnt_t = counter; m_addr = data_addr; m_we = data_we;
        end
      end
    end else if (!m_have_gnt && data_gnt) begin
      m_have_gnt = 1; m_gnt_t = counter; m_addr = data_addr; m_we = data_we;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    m_ovf_vis = m_ovf_next;
    #1;
    counter = counter + 1;
  endtask

  task automatic cyc(input bit rdy, input bit req, input bit gnt, input bit rv,
                     input bit we, input logic [31:0] addr);
    if_data_ready = rdy;
    data_req = req; data_gnt = gnt; data_rvalid = rv; data_we = we; data_addr = addr;
    tick();
  endtask

  task automatic push_instr(input logic [31:0] ins, input logic [15:0] ia,
                            input logic [31:0] de);
    if_instruction = ins; if_instr_addr = ia; dec_stage_end = de;
    cyc(1, 0, 0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    rec_t a, e;
    if (mon_en) begin
      checks++;
      if (overflow !== m_ovf_vis) begin
        failures++;
        $display("FAIL overflow: got %0b expected %0b at counter %0d", overflow, m_ovf_vis, counter);
      end
      if (trace_valid === 1'b1) begin
        a = {trace_instruction, trace_instr_addr, trace_dec_end, trace_mem_addr, trace_we,
             trace_req_time, trace_gnt_time, trace_rvalid_time, trace_orphan};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_trace: got %h expected no record", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL trace_record: got %h expected %h", a, e);
          end
        end
      end else if (trace_valid !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL trace_valid_x: got %b expected 0/1", trace_valid);
      end
    end
  end

  initial begin
    rst_n = 0; counter = 0;
    if_data_ready = 0; if_instruction = '0; if_instr_addr = '0; dec_stage_end = '0;
    data_req = 0; data_gnt = 0; data_rvalid = 0; data_we = 0; data_addr = '0;
    repeat (3) tick();

    checks++;
    if ({trace_valid, trace_instruction, trace_instr_addr, trace_dec_end, trace_mem_addr,
         trace_we, trace_req_time, trace_gnt_time, trace_rvalid_time, trace_orphan,
         overflow} !== '0) begin
      failures++;
      $display("FAIL reset_state: got nonzero outputs valid=%b ovf=%b instr=%h", trace_valid,
               overflow, trace_instruction);
    end
    rst_n = 1;
    mon_en = 1'b1;

    // Single load.
    push_instr(32'h0041_2083, 16'h0100, 32'd10);
    cyc(0, 0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, 32'h2000);
    cyc(0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);

    // Back-to-back with chained request in the rvalid cycle.
    push_instr(32'h1111_1111, 16'h0200, 32'd20);
    push_instr(32'h2222_2222, 16'h0204, 32'd21);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 1, 32'h3000);
    cyc(0, 1, 0, 1, 0, '0);
    cyc(0, 0, 1, 0, 0, 32'h3004);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);

    // Overflow: five pushes into a four-deep FIFO, then drain plus one orphan.
    for (int unsigned i = 0; i < 5; i++)
      push_instr(32'hA000_0000 + i, 16'(16'h0400 + 4 * i), 32'd100 + i);
    for (int unsigned i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, i[0], 32'h5000 + i);
      cyc(0, 0, 0, 1, 0, '0);
    end
    cyc(0, 0, 0, 0, 0, '0);

    // Reset while waiting for rvalid, then a stray rvalid.
    push_instr(32'h3333_3333, 16'h0300, 32'd30);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, 32'h6000);
    rst_n = 0;
    cyc(0, 0, 0, 0, 0, '0);
    rst_n = 1;
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);

    // Same-cycle req+gnt.
    cyc(0, 1, 1, 0, 1, 32'h7000);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);

    // Random traffic including simultaneous push/pop and occasional reset.
    for (int unsigned i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if_instruction = $urandom;
      if_instr_addr = 16'($urandom);
      dec_stage_end = $urandom;
      cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45,
          1'($urandom), $urandom);
    end
    rst_n = 1;
    repeat (4) cyc(0, 0, 0, 0, 0, '0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_records: got %0d outstanding expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
